// File: rtl/bram_stream_loader.sv
// Packs a host byte stream little-endian into BRAM-width words and issues
// one-cycle write strobes at consecutive addresses under a start/length command.
module bram_stream_loader #(
  parameter int WRITE_WIDTH      = 32,
  parameter int WRITE_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WRITE_ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]        byte_count,
  input  logic                        abort,
  input  logic                        s_valid,
  input  logic [7:0]                  s_data,
  output logic                        s_ready,
  output logic                        w_valid,
  output logic [WRITE_ADDR_WIDTH-1:0] w_addr,
  output logic [WRITE_WIDTH-1:0]      w_data,
  output logic                        busy,
  output logic                        done,
  output logic [WRITE_ADDR_WIDTH:0]   words_written,
  output logic                        overflow
);

  localparam int BPW    = WRITE_WIDTH / 8;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                      state_reg, state_next;
  logic                        drain_reg, drain_next;
  logic [WRITE_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]        remaining_reg, remaining_next;
  logic [LANE_W-1:0]           lane_reg, lane_next;
  logic [WRITE_WIDTH-1:0]      pack_reg, pack_next;
  logic                        w_valid_reg, w_valid_next;
  logic [WRITE_ADDR_WIDTH-1:0] w_addr_reg, w_addr_next;
  logic [WRITE_WIDTH-1:0]      w_data_reg, w_data_next;
  logic [WRITE_ADDR_WIDTH:0]   words_reg, words_next;
  logic                        overflow_reg, overflow_next;

  logic                        accept;
  logic                        last_byte;
  logic                        lane_last;
  logic                        word_done;
  logic [WRITE_WIDTH-1:0]      packed_word;

  // drain_reg marks the cycle after the last byte, when the final write is on the bus
  assign s_ready   = (state_reg == LOAD) && !drain_reg && !abort;
  assign accept    = s_valid && s_ready;
  assign last_byte = (remaining_reg == LEN_WIDTH'(1));
  assign lane_last = (lane_reg == LANE_W'(BPW - 1));
  assign word_done = accept && (lane_last || last_byte);

  generate
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      assign packed_word[gi*8 +: 8] = (lane_reg == LANE_W'(gi)) ? s_data : pack_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    drain_next     = drain_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    lane_next      = lane_reg;
    pack_next      = pack_reg;
    w_valid_next   = 1'b0;
    w_addr_next    = w_addr_reg;
    w_data_next    = w_data_reg;
    words_next     = words_reg;
    overflow_next  = overflow_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next      = base_addr;
          remaining_next = byte_count;
          lane_next      = '0;
          pack_next      = '0;
          words_next     = '0;
          overflow_next  = 1'b0;
          drain_next     = 1'b0;
          state_next     = (byte_count == '0) ? FINISH : LOAD;
        end
      end

      LOAD: begin
        if (drain_reg) begin
          drain_next = 1'b0;
          state_next = FINISH;
        end else if (abort) begin
          // partial word is dropped; any write already on the bus still lands
          lane_next  = '0;
          pack_next  = '0;
          state_next = FINISH;
        end else if (accept) begin
          remaining_next = remaining_reg - LEN_WIDTH'(1);
          if (word_done) begin
            w_valid_next = 1'b1;
            w_addr_next  = addr_reg;
            w_data_next  = packed_word;
            addr_next    = addr_reg + WRITE_ADDR_WIDTH'(1);
            words_next   = words_reg + (WRITE_ADDR_WIDTH+1)'(1);
            lane_next    = '0;
            pack_next    = '0;
            if (addr_reg == '1) begin
              overflow_next = 1'b1;
            end
          end else begin
            lane_next = lane_reg + LANE_W'(1);
            pack_next = packed_word;
          end
          if (last_byte) begin
            drain_next = 1'b1;
          end
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      drain_reg     <= 1'b0;
      addr_reg      <= '0;
      remaining_reg <= '0;
      lane_reg      <= '0;
      pack_reg      <= '0;
      w_valid_reg   <= 1'b0;
      w_addr_reg    <= '0;
      w_data_reg    <= '0;
      words_reg     <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_reg     <= drain_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      lane_reg      <= lane_next;
      pack_reg      <= pack_next;
      w_valid_reg   <= w_valid_next;
      w_addr_reg    <= w_addr_next;
      w_data_reg    <= w_data_next;
      words_reg     <= words_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign w_valid       = w_valid_reg;
  assign w_addr        = w_addr_reg;
  assign w_data        = w_data_reg;
  assign words_written = words_reg;
  assign overflow      = overflow_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == FINISH);

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader: a word-level scoreboard of expected
// BRAM writes plus literal spot values for each scenario.
module tb_bram_stream_loader;

  localparam int WW  = 32;
  localparam int AW  = 10;
  localparam int LW  = 16;
  localparam int BPW = WW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] byte_count = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready;
  logic          w_valid;
  logic [AW-1:0] w_addr;
  logic [WW-1:0] w_data;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;
  logic          overflow;

  always #5 clk = ~clk;

  bram_stream_loader #(
    .WRITE_WIDTH(WW),
    .WRITE_ADDR_WIDTH(AW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .byte_count(byte_count),
    .abort(abort),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .w_valid(w_valid),
    .w_addr(w_addr),
    .w_data(w_data),
    .busy(busy),
    .done(done),
    .words_written(words_written),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        act_q[$];
  logic [7:0] stim[$];
  int         gaps[6] = '{0, 3, 1, 2, 0, 1};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int w_cnt = 0;
  int last_w_cyc = -1;
  int ready_cnt = 0;
  int abort_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Per-cycle compare against the expected-write queue and the output invariants
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (abort) abort_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_ready) ready_cnt++;
    chk("s_ready_without_busy", 64'(s_ready && !busy), 64'd0);
    chk("w_valid_without_busy", 64'(w_valid && !busy), 64'd0);
    if (w_valid) begin
      w_cnt++;
      last_w_cyc = cyc;
      act_q.push_back({w_addr, w_data});
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h required no write", w_addr, w_data);
      end else begin
        e = exp_q.pop_front();
        chk("w_addr", 64'(w_addr), 64'(e.addr));
        chk("w_data", 64'(w_data), 64'(e.data));
      end
    end
  end

  // Word-level model: which writes a load must produce, and the resulting status
  task automatic build_expect(input logic [AW-1:0] base, input int cnt, input int abort_after,
                              output int nwords, output bit ovf, output logic [AW-1:0] last_addr);
    int            neff;
    logic [WW-1:0] word;
    logic [AW-1:0] a;
    neff = cnt;
    if (abort_after >= 0 && abort_after < cnt) neff = (abort_after / BPW) * BPW;
    nwords = (neff + BPW - 1) / BPW;
    for (int w = 0; w < nwords; w++) begin
      word = '0;
      for (int l = 0; l < BPW; l++) begin
        if (w * BPW + l < neff) word[8*l +: 8] = stim[w * BPW + l];
      end
      a = base + AW'(w);
      exp_q.push_back({a, word});
    end
    ovf = (int'(base) + nwords) > ((1 << AW) - 1);
    last_addr = base + AW'(nwords - 1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit ok;
    int t;
    ok = 1'b0;
    t = 0;
    s_valid = 1'b1;
    s_data = b;
    while (!ok && t < 40) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      t++;
    end
    s_valid = 1'b0;
    s_data = 8'($urandom);
    chk("byte_accepted", 64'(ok), 64'd1);
  endtask

  task automatic chk_act(input int idx, input logic [AW-1:0] a, input logic [WW-1:0] d);
    if (idx >= act_q.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL write_missing: got %0d writes required more than %0d", act_q.size(), idx);
    end else begin
      chk("literal_addr", 64'(act_q[idx].addr), 64'(a));
      chk("literal_data", 64'(act_q[idx].data), 64'(d));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_w_valid"}, 64'(w_valid), 64'd0);
    chk({tag, "_w_addr"}, 64'(w_addr), 64'd0);
    chk({tag, "_w_data"}, 64'(w_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_words_written"}, 64'(words_written), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  task automatic run_load(input logic [AW-1:0] base, input int cnt, input bit use_gaps,
                          input int abort_after, input bit extra_start);
    int            nwords, d0, w0, r0, sc, g;
    bit            ovf, aborted;
    logic [AW-1:0] la;
    aborted = 1'b0;
    act_q.delete();
    build_expect(base, cnt, abort_after, nwords, ovf, la);
    d0 = done_cnt;
    w0 = w_cnt;
    r0 = ready_cnt;
    base_addr = base;
    byte_count = LW'(cnt);
    start = 1'b1;
    @(posedge clk);
    sc = cyc;
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    byte_count = LW'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    if (cnt > 0) chk("overflow_cleared_on_start", 64'(overflow), 64'd0);
    for (int i = 0; i < cnt; i++) begin
      if (i == abort_after) begin
        abort = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h5A;
        @(posedge clk);
        #1;
        abort = 1'b0;
        s_valid = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (extra_start && i == 2) begin
        start = 1'b1;
        base_addr = 10'h155;
        byte_count = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      g = use_gaps ? gaps[i % 6] : 0;
      repeat (g) @(posedge clk);
      if (g > 0) #1;
      push_byte(stim[i]);
    end
    if (cnt > 0 && !aborted) begin
      @(negedge clk);
      #1;
      chk("s_ready_after_last", 64'(s_ready), 64'd0);
    end
    for (int k = 0; k < 20 && done_cnt == d0; k++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    if (aborted) chk("done_after_abort", 64'(done_cyc), 64'(abort_cyc + 1));
    else if (cnt == 0) chk("done_latency_zero", 64'(done_cyc > sc && done_cyc - sc <= 2), 64'd1);
    else chk("done_after_last_write", 64'(done_cyc), 64'(last_w_cyc + 1));
    chk("write_count", 64'(w_cnt - w0), 64'(nwords));
    chk("expected_writes_left", 64'(exp_q.size()), 64'd0);
    chk("words_written", 64'(words_written), 64'(nwords));
    chk("overflow", 64'(overflow), 64'(ovf));
    chk("busy_idle", 64'(busy), 64'd0);
    if (nwords > 0) chk("w_addr_hold", 64'(w_addr), 64'(la));
    if (cnt == 0) chk("s_ready_never_zero_len", 64'(ready_cnt - r0), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // full words, back-to-back
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'(i + 1));
    run_load(10'h010, 8, 1'b0, -1, 1'b0);
    chk_act(0, 10'h010, 32'h04030201);
    chk_act(1, 10'h011, 32'h08070605);
    chk("full_words_written", 64'(words_written), 64'd2);

    // partial tail with gaps and an ignored start mid-load
    stim.delete();
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load(10'h020, 6, 1'b1, -1, 1'b1);
    chk_act(0, 10'h020, 32'hDDCCBBAA);
    chk_act(1, 10'h021, 32'h0000FFEE);

    // address wrap
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'(8'h11 * (i + 1)));
    run_load(10'h3FF, 8, 1'b0, -1, 1'b0);
    chk_act(0, 10'h3FF, 32'h44332211);
    chk_act(1, 10'h000, 32'h88776655);
    chk("wrap_overflow", 64'(overflow), 64'd1);

    // abort after 6 bytes, then abort coinciding with a write
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'(8'h21 + i));
    run_load(10'h100, 12, 1'b0, 6, 1'b0);
    chk_act(0, 10'h100, 32'h24232221);
    chk("abort_words_written", 64'(words_written), 64'd1);
    run_load(10'h200, 12, 1'b0, 8, 1'b0);
    chk("abort_sched_words", 64'(words_written), 64'd2);

    // zero length
    run_load(10'h050, 0, 1'b0, -1, 1'b0);

    // asynchronous reset between 2nd and 3rd byte
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'(i + 1));
    base_addr = 10'h010;
    byte_count = 16'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_byte(stim[0]);
    push_byte(stim[1]);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_busy", 64'(busy), 64'd0);
      chk("post_reset_s_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    run_load(10'h010, 8, 1'b0, -1, 1'b0);
    chk_act(0, 10'h010, 32'h04030201);
    chk_act(1, 10'h011, 32'h08070605);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_stream_loader.md
Name: bram_stream_loader

Overview:
- Upstream feeder for the dual-width instruction BRAM write port.
- Accepts a byte stream from the host link (SPI/UART bridge) under valid/ready, packs bytes little-endian into WRITE_WIDTH-bit words and issues one-cycle BRAM write strobes at consecutive addresses.
- Controlled by a start/length command; reports busy, done, word count and address overflow to the control FSM.

Parameters:
WRITE_WIDTH, 32, BRAM write-port data width; must be a multiple of 8, >= 8
WRITE_ADDR_WIDTH, 10, BRAM write-port address width
LEN_WIDTH, 16, width of the byte-count command field
BPW (localparam), WRITE_WIDTH/8, bytes per word

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle command pulse; sampled only in IDLE
base_addr  input  WRITE_ADDR_WIDTH  first BRAM word address, latched on accepted start
byte_count  input  LEN_WIDTH  number of bytes to load, latched on accepted start
abort  input  1  synchronous cancel of the current load
s_valid  input  1  stream byte valid
s_data  input  8  stream byte
s_ready  output  1  loader accepts a byte this cycle
w_valid  output  1  BRAM write strobe
w_addr  output  WRITE_ADDR_WIDTH  BRAM write address
w_data  output  WRITE_WIDTH  BRAM write data
busy  output  1  load in progress
done  output  1  one-cycle completion pulse
words_written  output  WRITE_ADDR_WIDTH+1  words written by the current/last load
overflow  output  1  sticky: address wrapped during load

Behaviour:
- Reset (rst=0, any time, asynchronous): state IDLE; s_ready, w_valid, busy, done and overflow = 0; w_addr, w_data, words_written, lane, remaining and the pack register = 0. A partial word in flight is discarded and no write is issued.
- States: IDLE, LOAD, FINISH.
- IDLE:
  - s_ready = 0.
  - start with byte_count > 0: latch base_addr into the address counter and byte_count into remaining; clear lane, pack register, words_written and overflow; next state LOAD, busy = 1 from the next cycle.
  - start with byte_count = 0: go to FINISH and issue no writes.
- LOAD:
  - s_ready = 1 combinationally, except when abort = 1.
  - Handshake occurs when s_valid & s_ready.
  - Each accepted byte goes into lane `lane` (first byte → bits [7:0]); then lane++ and remaining--.
  - A word completes when the accepted byte is in lane BPW-1, or is the last byte (remaining == 1).
  - On word completion, the following cycle: w_valid = 1 for exactly one cycle, w_addr = address counter, w_data = packed word. Unfilled upper lanes are 0.
  - After each write: address counter++, words_written++; lane and pack register clear.
  - Throughput is one byte per cycle. s_ready stays high while a write is issued, and the next byte lands in lane 0 of the fresh word.
  - Last byte accepted: s_ready = 0 from the next cycle, the final write is issued, then go to FINISH.
- FINISH: done = 1 for one cycle, busy = 0 on the next cycle, return to IDLE. Outputs w_addr and w_data hold their last values.
- Address wrap: incrementing from 2^WRITE_ADDR_WIDTH-1 wraps to 0 and sets overflow. overflow is sticky until the next accepted start. Loading continues after a wrap.
- abort in LOAD:
  - No byte is accepted that cycle.
  - The partial word is discarded without a write.
  - A write already scheduled for that cycle still completes.
  - Next state FINISH (done pulses). words_written reflects only completed writes.
- start while busy is ignored. abort in IDLE or FINISH is ignored.
- s_data is don't-care when s_valid = 0. w_valid never asserts outside LOAD and the cycle after the last byte.

Test Plan:
- Full words: reset, start with base_addr=0x010, byte_count=8, bytes 01..08 back-to-back → w_valid at 0x010 data 0x04030201, then at 0x011 data 0x08070605; done one cycle later; words_written=2; overflow=0.
- Partial tail: byte_count=6, bytes AA BB CC DD EE FF with s_valid gaps of 0-3 cycles → writes 0xDDCCBBAA, then 0x0000FFEE; s_ready=0 after the 6th byte; exactly two w_valid pulses.
- Wrap: base_addr=0x3FF, byte_count=8 → writes to 0x3FF then 0x000; overflow=1 after completion; overflow clears on the next start.
- Zero length and ignored start: byte_count=0 → done within 2 cycles, no w_valid, s_ready never 1. A second start while busy leaves base_addr and byte_count unchanged.
- Abort: byte_count=12; after 6 bytes assert abort for one cycle → exactly one write (bytes 1-4), partial bytes 5-6 dropped, done pulses, words_written=1.
- Async reset mid-load: deassert-to-0 rst between the 2nd and 3rd byte → all outputs 0 immediately with no clock edge, no w_valid; after release the block sits in IDLE and a fresh load behaves as in the full-words test.
